// File: rtl/shiftreg_wrap.sv
// shiftreg_wrap: Depth-stage valid/data pipeline with one beat per cycle and no backpressure.
// Define SHIFTREG_DATA_RESET_EN to give the stage data registers an asynchronous reset to 0.
module shiftreg_wrap #(
   parameter int Depth     = 4,
   parameter int DataWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 valid_i,
   input  logic [DataWidth-1:0] data_i,
   output logic                 valid_o,
   output logic [DataWidth-1:0] data_o
);

   if (Depth < 1 || Depth > 64) begin : g_depth_check
      $error("shiftreg_wrap: Depth %0d outside legal range 1..64", Depth);
   end
   if (DataWidth < 1 || DataWidth > 1024) begin : g_width_check
      $error("shiftreg_wrap: DataWidth %0d outside legal range 1..1024", DataWidth);
   end

   logic [Depth-1:0]     r_valid;
   logic [DataWidth-1:0] r_data    [Depth];
   logic [Depth-1:0]     w_load;
   logic [DataWidth-1:0] w_data_in [Depth];

   // Per-stage upstream valid/data: stage 0 sees the ports, stage k sees stage k-1.
   always_comb begin
      w_load       = '0;
      w_data_in    = '{default: '0};
      w_load[0]    = valid_i;
      w_data_in[0] = data_i;
      for (int k = 1; k < Depth; k++) begin
         w_load[k]    = r_valid[k-1];
         w_data_in[k] = r_data[k-1];
      end
   end

   // Valid bits shift every cycle, bubbles included.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid <= '0;
      end else begin
         for (int k = 0; k < Depth; k++) begin
            r_valid[k] <= w_load[k];
         end
      end
   end

`ifdef SHIFTREG_DATA_RESET_EN
   // Data words advance only behind a valid bit, so gaps keep the last payload.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < Depth; k++) begin
            r_data[k] <= '0;
         end
      end else begin
         for (int k = 0; k < Depth; k++) begin
            if (w_load[k]) begin
               r_data[k] <= w_data_in[k];
            end
         end
      end
   end
`else
   // Data words advance only behind a valid bit; no reset on the wide datapath.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < Depth; k++) begin
         if (w_load[k]) begin
            r_data[k] <= w_data_in[k];
         end
      end
   end
`endif

   assign valid_o = r_valid[Depth-1];
   assign data_o  = r_data[Depth-1];

endmodule

// File: tb/tb_shiftreg_wrap.sv
// Self-checking bench for shiftreg_wrap: vector table, hand-written reset sequences,
// and randomized traffic checked against a history-based reference model (Depth 4 and 1).
module tb_shiftreg_wrap;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vi;
   logic [31:0] di;
   logic        v4, v1;
   logic [31:0] d4, d1;

   always #5 clk = ~clk;

   shiftreg_wrap #(.Depth(4), .DataWidth(32)) u_dut4 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(vi), .data_i(di), .valid_o(v4), .data_o(d4)
   );
   shiftreg_wrap #(.Depth(1), .DataWidth(32)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(vi), .data_i(di), .valid_o(v1), .data_o(d1)
   );

   typedef struct packed {
      logic        v;
      logic [31:0] d;
   } beat_t;

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        ev;
      logic [31:0] ed;
      logic        cd;
   } vec_t;

   // Every beat sampled since the last reset, one entry per rising edge.
   beat_t hist[$];
   int    checks = 0;
   int    errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Output after the latest edge of a depth-d pipe: the beat sampled d-1 edges ago,
   // and the payload of the most recent valid beat that has already emerged.
   task automatic expect_out(input int d, output logic ev, output logic [31:0] ed, output bit known);
      int n;
      n     = hist.size();
      ev    = 1'b0;
      ed    = 32'h0;
      known = 1'b0;
`ifdef SHIFTREG_DATA_RESET_EN
      known = 1'b1;
`endif
      if (n >= d) ev = hist[n-d].v;
      for (int i = n - d; i >= 0; i--) begin
         if (hist[i].v) begin
            ed    = hist[i].d;
            known = 1'b1;
            break;
         end
      end
   endtask

   task automatic model_check();
      logic        ev;
      logic [31:0] ed;
      bit          known;
      expect_out(4, ev, ed, known);
      check("model_valid_d4", {31'b0, v4}, {31'b0, ev});
      if (known) check("model_data_d4", d4, ed);
      expect_out(1, ev, ed, known);
      check("model_valid_d1", {31'b0, v1}, {31'b0, ev});
      if (known) check("model_data_d1", d1, ed);
   endtask

   // Drive one beat, clock it in, then compare both pipes against the model.
   task automatic step(input logic v, input logic [31:0] d);
      vi = v;
      di = d;
      @(posedge clk);
      hist.push_back('{v, d});
      #1;
      model_check();
   endtask

   // Assert reset between edges, confirm valid drops before the next edge, release after it.
   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      hist.delete();
      #1;
      check("async_rst_valid_d4", {31'b0, v4}, 32'h0);
      check("async_rst_valid_d1", {31'b0, v1}, 32'h0);
`ifdef SHIFTREG_DATA_RESET_EN
      check("async_rst_data_d4", d4, 32'h0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   vec_t tbl[13];

   initial begin
      tbl[0]  = '{1'b1, 32'h12153524, 1'b0, 32'h0,        1'b0};
      tbl[1]  = '{1'b1, 32'hC0895E81, 1'b0, 32'h0,        1'b0};
      tbl[2]  = '{1'b1, 32'h8484D609, 1'b0, 32'h0,        1'b0};
      tbl[3]  = '{1'b1, 32'hB1F05663, 1'b1, 32'h12153524, 1'b1};
      tbl[4]  = '{1'b0, 32'hDEADBEEF, 1'b1, 32'hC0895E81, 1'b1};
      tbl[5]  = '{1'b1, 32'hAAAA0001, 1'b1, 32'h8484D609, 1'b1};
      tbl[6]  = '{1'b0, 32'h0BADF00D, 1'b1, 32'hB1F05663, 1'b1};
      tbl[7]  = '{1'b1, 32'hAAAA0002, 1'b0, 32'hB1F05663, 1'b1};
      tbl[8]  = '{1'b0, 32'h11111111, 1'b1, 32'hAAAA0001, 1'b1};
      tbl[9]  = '{1'b0, 32'h22222222, 1'b0, 32'hAAAA0001, 1'b1};
      tbl[10] = '{1'b0, 32'h33333333, 1'b1, 32'hAAAA0002, 1'b1};
      tbl[11] = '{1'b0, 32'h44444444, 1'b0, 32'hAAAA0002, 1'b1};
      tbl[12] = '{1'b0, 32'h55555555, 1'b0, 32'hAAAA0002, 1'b1};

      rst_n = 1'b0;
      vi    = 1'b0;
      di    = 32'h0;
      repeat (20) @(posedge clk);
      #1;
      check("reset_valid_d4", {31'b0, v4}, 32'h0);
      check("reset_valid_d1", {31'b0, v1}, 32'h0);
`ifdef SHIFTREG_DATA_RESET_EN
      check("reset_data_d4", d4, 32'h0);
      check("reset_data_d1", d1, 32'h0);
`endif
      rst_n = 1'b1;

      // Burst of four, then a single-bubble gap pattern.
      for (int i = 0; i < 13; i++) begin
         step(tbl[i].v, tbl[i].d);
         check($sformatf("tbl_valid_%0d", i), {31'b0, v4}, {31'b0, tbl[i].ev});
         if (tbl[i].cd) check($sformatf("tbl_data_%0d", i), d4, tbl[i].ed);
      end

      // Depth-1 pipe: one edge of latency.
      step(1'b1, 32'h3);
      check("d1_valid_after_one_edge", {31'b0, v1}, 32'h1);
      check("d1_data_after_one_edge", d1, 32'h3);
      step(1'b0, 32'h0);
      step(1'b0, 32'h0);
      step(1'b0, 32'h0);

      // Two beats in flight, reset before they emerge, then a fresh beat.
      step(1'b1, 32'hA5A5A5A5);
      step(1'b1, 32'h5A5A5A5A);
      async_reset();
      step(1'b1, 32'h5);
      check("post_rst_lat1", {31'b0, v4}, 32'h0);
      step(1'b0, 32'h0);
      check("post_rst_lat2", {31'b0, v4}, 32'h0);
      step(1'b0, 32'h0);
      check("post_rst_lat3", {31'b0, v4}, 32'h0);
      step(1'b0, 32'h0);
      check("post_rst_lat4_valid", {31'b0, v4}, 32'h1);
      check("post_rst_lat4_data", d4, 32'h5);
      step(1'b0, 32'h0);
      check("post_rst_single", {31'b0, v4}, 32'h0);

      // Reset while the output is valid must drop valid_o before the next edge.
      for (int i = 0; i < 4; i++) step(1'b1, 32'hC0DE0000 + 32'(i));
      check("pre_async_valid", {31'b0, v4}, 32'h1);
      async_reset();
      for (int i = 0; i < 5; i++) step(1'b0, 32'h0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) async_reset();
         else step(logic'($urandom_range(0, 3) != 0), 32'($urandom()));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
